wallace_mult8x8_seq: RTL and testbench
======================================

# wallace_mult8x8_seq

Iterative 8x8 unsigned multiplier built around one 4x4 Wallace tree multiplier. It splits the operands into nibbles and feeds the four nibble pairs through the tree on successive cycles. Each 8-bit product is shifted and accumulated into a 16-bit result. It is the stage directly upstream of the 4x4 tree: it generates the tree's operands and consumes its products. It is the next step toward wider multipliers in the datapath.

## Interface
- CLEAR_ON_START, default 0:
  - 1: Product is cleared to 0 in the cycle after a Start is accepted.
  - 0: Product holds the previous result until the new one is written.
- Clk  input  1  — sole clock; all state updates on rising edge.
- Reset_n  input  1  — reset is asynchronous and active-low.
- Start  input  1  — request; sampled on rising edge; accepted only in IDLE or DONE.
- A  input  8  — multiplicand; captured on accepted Start.
- B  input  8  — multiplier; captured on accepted Start.
- Product  output  16  — result register; valid from the Done cycle and held until overwritten.
- Busy  output  1  — high while a multiply is in progress (state MUL).
- Done  output  1  — one-cycle pulse; Product is valid in this cycle.

## Operation
- Reset values: Product=16'h0000, Busy=0, Done=0, state=IDLE, step counter=0, accumulator=0.
- States:
  - IDLE: waiting for Start.
  - MUL: step counter 0..3.
  - DONE: one cycle.
- IDLE --Start--> MUL. Captures A into a_q and B into b_q, and clears the accumulator and step counter to 0.
- MUL, one step per cycle. The tree operands are driven combinationally from the step counter:
  - step 0: a_q[3:0] x b_q[3:0], shift 0
  - step 1: a_q[7:4] x b_q[3:0], shift 4
  - step 2: a_q[3:0] x b_q[7:4], shift 4
  - step 3: a_q[7:4] x b_q[7:4], shift 8
- Each MUL cycle, the accumulator (16 bits) is updated as acc + ({8'h00, pp} << shift). The sum never exceeds 16'hFE01, so no overflow or carry-out handling is needed.
- MUL step 3 --> DONE. Product <= final accumulator value. Busy falls.
- DONE:
  - Done=1.
  - With Start=1, goes directly to MUL (back-to-back, same capture as from IDLE).
  - Otherwise goes to IDLE.
- Start while in MUL is ignored. The in-flight operands are unaffected, and no queueing occurs.
- Changes on A/B after capture have no effect on the in-flight result.
- Reset asserted mid-operation aborts immediately. All outputs and state return to reset values asynchronously, and no Done is produced.

## Timing
- Start sampled high at edge k (IDLE or DONE):
  - Busy=1 after edge k through edge k+4.
  - Steps 0..3 accumulate at edges k+1..k+4.
  - Product is written at edge k+4.
  - Done=1 for the cycle between edges k+4 and k+5.
- Latency:
  - 4 cycles from accepted Start to Product valid.
  - Throughput is one result per 5 cycles with back-to-back Start held high.
- Busy and Done are never high simultaneously.
- Done is exactly one cycle wide, even when Start is held high.
- CLEAR_ON_START=1: Product=0 is visible from edge k+1 until edge k+4.
- The tree path is purely combinational: nibble mux → 4x4 tree → shift → 16-bit adder within one cycle.
- Reset deassertion is synchronised externally. The block leaves IDLE only on the first Start sampled after reset deassertion.

## Structure
- Shared package:
  - state encoding (IDLE, MUL, DONE)
  - STEP_LAST=2'd3
  - the shift amounts per step (0, 4, 4, 8)
- Natural sub-module: one instance of the existing WallaceTree4x4 (ports A[3:0], B[3:0], Product[7:0]).
- Nothing else is instantiated. The nibble mux, shifter, accumulator and FSM are local.

## Test plan
- Reset, then idle for 10 cycles → Product=0x0000, Busy=0, Done=0 throughout.
- A=0x12, B=0x34, Start for 1 cycle → Busy for 4 cycles, then Done pulse with Product=0x03A8.
- A=0xFF, B=0xFF → Product=0xFE01. A=0x00, B=0xA5 → Product=0x0000. A=0x10, B=0x01 → Product=0x0010.
- Start held high with A=0x0F, B=0xF0 then A=0x80, B=0x02 presented at the Done cycle → Product=0x0E10, then Product=0x0100 five cycles later. Toggle Start and change A/B while Busy → no effect on the result.
- Assert Reset_n low at step 2 of 0xAB x 0xCD → Product=0, Busy=0, no Done. A subsequent Start with 0xAB x 0xCD → Product=0x88EF.
- CLEAR_ON_START=1: run 0x12 x 0x34, then start 0x02 x 0x03 → Product reads 0 during Busy, then 0x0006 at Done. With 0, Product stays 0x03A8 until then.

Source files
------------

// File: rtl/wallace_mult8x8_seq_pkg.sv
// Shared types and constants for the iterative 8x8 multiplier built on one 4x4 Wallace tree.
package wallace_mult8x8_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [1:0] STEP_LAST = 2'd3;

    typedef struct packed {
        logic [3:0] a;
        logic [3:0] b;
    } nib_pair_t;

    // Left shift applied to the 4x4 partial product at each step (0, 4, 4, 8).
    function automatic logic [3:0] step_shift(input logic [1:0] step);
        case (step)
            2'd0:    return 4'd0;
            2'd1:    return 4'd4;
            2'd2:    return 4'd4;
            default: return 4'd8;
        endcase
    endfunction

    function automatic nib_pair_t select_nibbles(input logic [1:0] step,
                                                 input logic [7:0] a,
                                                 input logic [7:0] b);
        nib_pair_t p;
        case (step)
            2'd0: begin p.a = a[3:0]; p.b = b[3:0]; end
            2'd1: begin p.a = a[7:4]; p.b = b[3:0]; end
            2'd2: begin p.a = a[3:0]; p.b = b[7:4]; end
            default: begin p.a = a[7:4]; p.b = b[7:4]; end
        endcase
        return p;
    endfunction

endpackage

// File: rtl/wallace_mult8x8_seq_tree.sv
// 4x4 unsigned Wallace tree multiplier: two carry-save 3:2 levels then one final adder.
module WallaceTree4x4 (
    input  logic [3:0] A,
    input  logic [3:0] B,
    output logic [7:0] Product
);

    logic [7:0] r0, r1, r2, r3;
    logic [7:0] s1, m1, c1;
    logic [7:0] s2, m2, c2;

    assign r0 = {4'b0000, A & {4{B[0]}}};
    assign r1 = {3'b000, A & {4{B[1]}}, 1'b0};
    assign r2 = {2'b00, A & {4{B[2]}}, 2'b00};
    assign r3 = {1'b0, A & {4{B[3]}}, 3'b000};

    // Carries never leave bit 7: the true product is at most 225.
    assign s1 = r0 ^ r1 ^ r2;
    assign m1 = (r0 & r1) | (r0 & r2) | (r1 & r2);
    assign c1 = {m1[6:0], 1'b0};

    assign s2 = s1 ^ c1 ^ r3;
    assign m2 = (s1 & c1) | (s1 & r3) | (c1 & r3);
    assign c2 = {m2[6:0], 1'b0};

    assign Product = s2 + c2;

endmodule

// File: rtl/wallace_mult8x8_seq.sv
// Iterative 8x8 unsigned multiplier: four nibble products through one 4x4 tree, shift-accumulated.
module wallace_mult8x8_seq
    import wallace_mult8x8_seq_pkg::*;
#(
    parameter bit CLEAR_ON_START = 1'b0
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic        Start,
    input  logic [7:0]  A,
    input  logic [7:0]  B,
    output logic [15:0] Product,
    output logic        Busy,
    output logic        Done
);

    state_t      state, state_next;
    logic [7:0]  a_q, b_q;
    logic [1:0]  step;
    logic [15:0] acc, acc_next, product_q;
    logic        accept;
    nib_pair_t   nib;
    logic [7:0]  pp;

    assign accept = Start && (state == ST_IDLE || state == ST_DONE);
    assign nib    = select_nibbles(step, a_q, b_q);

    WallaceTree4x4 u_tree (
        .A       (nib.a),
        .B       (nib.b),
        .Product (pp)
    );

    assign acc_next = acc + ({8'h00, pp} << step_shift(step));

    // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) state <= ST_IDLE;
        else          state <= state_next;
    end

    // NOTE: default assignment first so no path through the case leaves state_next unassigned (no latch).
    always_comb begin
        state_next = state;
        unique case (state)
            ST_IDLE: if (Start) state_next = ST_MUL;
            ST_MUL:  if (step == STEP_LAST) state_next = ST_DONE;
            ST_DONE: state_next = Start ? ST_MUL : ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        Busy = (state == ST_MUL);
        Done = (state == ST_DONE);
    end

    // Start during MUL is ignored: accept only fires from IDLE/DONE.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            a_q       <= 8'h00;
            b_q       <= 8'h00;
            step      <= 2'd0;
            acc       <= 16'h0000;
            product_q <= 16'h0000;
        end else if (accept) begin
            a_q  <= A;
            b_q  <= B;
            step <= 2'd0;
            acc  <= 16'h0000;
            if (CLEAR_ON_START) product_q <= 16'h0000;
        end else if (state == ST_MUL) begin
            acc  <= acc_next;
            step <= step + 2'd1;
            if (step == STEP_LAST) product_q <= acc_next;
        end
    end

    assign Product = product_q;

endmodule

// File: tb/tb_wallace_mult8x8_seq.sv
// Self-checking bench: cycle model of both CLEAR_ON_START variants plus directed literal checks.
module tb_wallace_mult8x8_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [7:0]  a, b;
    logic [15:0] prod0, prod1;
    logic        busy0, busy1, done0, done1;

    int total = 0;
    int bad   = 0;

    wallace_mult8x8_seq #(.CLEAR_ON_START(1'b0)) dut0 (
        .Clk(clk), .Reset_n(rst_n), .Start(start), .A(a), .B(b),
        .Product(prod0), .Busy(busy0), .Done(done0)
    );

    wallace_mult8x8_seq #(.CLEAR_ON_START(1'b1)) dut1 (
        .Clk(clk), .Reset_n(rst_n), .Start(start), .A(a), .B(b),
        .Product(prod1), .Busy(busy1), .Done(done1)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: m_cnt = cycles since accepted start (1..4 busy, 5 done, 0 idle).
    int          m_cnt;
    logic [15:0] m_res, m_p0, m_p1;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_cnt <= 0; m_res <= 16'h0; m_p0 <= 16'h0; m_p1 <= 16'h0;
        end else if ((m_cnt == 0 || m_cnt == 5) && start) begin
            m_cnt <= 1;
            m_res <= 16'(a) * 16'(b);
            m_p1  <= 16'h0;
        end else if (m_cnt >= 1 && m_cnt <= 3) begin
            m_cnt <= m_cnt + 1;
        end else if (m_cnt == 4) begin
            m_cnt <= 5; m_p0 <= m_res; m_p1 <= m_res;
        end else begin
            m_cnt <= 0;
        end
    end

    always @(negedge clk) begin
        check("busy0", busy0, (m_cnt >= 1 && m_cnt <= 4));
        check("done0", done0, (m_cnt == 5));
        check("prod0", prod0, m_p0);
        check("busy1", busy1, (m_cnt >= 1 && m_cnt <= 4));
        check("done1", done1, (m_cnt == 5));
        check("prod1", prod1, m_p1);
        check("excl0", busy0 & done0, 1'b0);
    end

    task automatic tick;
        @(negedge clk);
        #1;
    endtask

    task automatic wait_done(output int cyc);
        cyc = 0;
        while (!done0 && cyc < 12) begin
            tick();
            cyc++;
        end
        check("done_seen", done0, 1'b1);
    endtask

    task automatic run_mul(input logic [7:0] ai, input logic [7:0] bi, input logic [15:0] exp);
        int cyc;
        start = 1'b1; a = ai; b = bi;
        tick();
        start = 1'b0;
        wait_done(cyc);
        check("latency", cyc, 4);
        check("lit_prod0", prod0, exp);
        check("lit_prod1", prod1, exp);
    endtask

    initial begin
        int cyc;
        rst_n = 1'b0; start = 1'b0; a = 8'h00; b = 8'h00;
        repeat (3) tick();
        check("rst_prod", prod0, 16'h0000);
        check("rst_busy", busy0, 1'b0);
        check("rst_done", done0, 1'b0);
        rst_n = 1'b1;
        repeat (10) tick();
        check("idle_prod", prod0, 16'h0000);

        run_mul(8'h12, 8'h34, 16'h03A8);
        run_mul(8'hFF, 8'hFF, 16'hFE01);
        run_mul(8'h00, 8'hA5, 16'h0000);
        run_mul(8'h10, 8'h01, 16'h0010);

        // Back-to-back with Start held high; new operands appear in the Done cycle.
        start = 1'b1; a = 8'h0F; b = 8'hF0;
        tick();
        wait_done(cyc);
        check("b2b_first", prod0, 16'h0E10);
        a = 8'h80; b = 8'h02;
        tick();
        start = 1'b0;
        check("b2b_done_width", done0, 1'b0);
        wait_done(cyc);
        check("b2b_period", cyc + 1, 5);
        check("b2b_second", prod0, 16'h0100);

        // Start toggling and operand changes while busy must not disturb the result.
        start = 1'b1; a = 8'h12; b = 8'h34;
        tick();
        repeat (3) begin
            start = ~start;
            a = 8'($urandom);
            b = 8'($urandom);
            tick();
        end
        start = 1'b0;
        wait_done(cyc);
        check("busy_ignore", prod0, 16'h03A8);
        tick();

        // Abort with reset at step 2.
        start = 1'b1; a = 8'hAB; b = 8'hCD;
        tick();
        start = 1'b0;
        repeat (2) tick();
        rst_n = 1'b0;
        #1;
        check("abort_prod", prod0, 16'h0000);
        check("abort_busy", busy0, 1'b0);
        check("abort_done", done0, 1'b0);
        tick();
        rst_n = 1'b1;
        repeat (3) tick();
        check("abort_nodone", done0, 1'b0);
        run_mul(8'hAB, 8'hCD, 16'h88EF);

        // CLEAR_ON_START: variant 1 reads zero while busy, variant 0 holds the old result.
        run_mul(8'h12, 8'h34, 16'h03A8);
        start = 1'b1; a = 8'h02; b = 8'h03;
        tick();
        start = 1'b0;
        repeat (4) begin
            check("clr_prod1", prod1, 16'h0000);
            check("hold_prod0", prod0, 16'h03A8);
            tick();
        end
        check("clr_done", done0, 1'b1);
        check("clr_final0", prod0, 16'h0006);
        check("clr_final1", prod1, 16'h0006);
        repeat (2) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
